// File: rtl/user_io_test_core.sv
// Pad-side IO test core: selectable loopback, counter, PRBS15 generator and
// self-synchronising counter checker between the ui and uo pad buses.
module user_io_test_core #(
  parameter int unsigned WIDTH       = 17,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             io_clock,
  input  logic             io_reset,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] uo_out,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned LFSR_W  = 15;
  localparam int unsigned MATCH_W = 8;

  typedef enum logic [1:0] {
    MODE_LOOP  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  mode_e               r_mode_q;
  chk_state_e          r_state;
  logic [WIDTH-1:0]    r_cnt;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [WIDTH-1:0]    r_exp;
  logic [WIDTH-1:0]    r_prev;
  logic                r_prev_vld;

  logic [WIDTH-1:0]    w_loop;
  logic [WIDTH-1:0]    w_prbs;
  logic                w_mode_chg;
  logic                w_lfsr_fb;
  logic                w_inc_match;
  logic                w_err_sat;

  assign w_mode_chg  = (mode_e'(mode) != r_mode_q);
  assign w_lfsr_fb   = r_lfsr[14] ^ r_lfsr[13];
  assign w_inc_match = r_prev_vld && (ui_in == (r_prev + WIDTH'(1)));
  assign w_err_sat   = &err_count;

  // PRBS output repeats the 15-bit state across wider buses
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prbs
    assign w_prbs[gi] = r_lfsr[gi % LFSR_W];
  end

  // Loopback pipe: PIPE_STAGES-1 registers ahead of uo_out; only reset clears it
  if (PIPE_STAGES == 1) begin : g_pipe_none
    assign w_loop = ui_in;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_pipe [PIPE_STAGES-1];

    always_ff @(posedge io_clock) begin
      if (io_reset) begin
        for (int i = 0; i < int'(PIPE_STAGES) - 1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= ui_in;
        for (int i = 1; i < int'(PIPE_STAGES) - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_loop = r_pipe[PIPE_STAGES-2];
  end

  // Mode register, generators, checker FSM and registered outputs
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_mode_q    <= MODE_LOOP;
      r_state     <= ST_HUNT;
      r_cnt       <= '0;
      r_lfsr      <= '1;
      r_match_cnt <= '0;
      r_exp       <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      uo_out      <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      r_mode_q  <= mode_e'(mode);
      err_pulse <= 1'b0;

      case (r_mode_q)
        MODE_LOOP:  uo_out <= w_loop;
        MODE_COUNT: uo_out <= r_cnt;
        MODE_PRBS:  uo_out <= w_prbs;
        MODE_CHECK: uo_out <= '0;
      endcase

      if (w_mode_chg) begin
        r_cnt       <= '0;
        r_lfsr      <= '1;
        r_state     <= ST_HUNT;
        r_match_cnt <= '0;
        r_prev_vld  <= 1'b0;
        locked      <= 1'b0;
        err_count   <= '0;
      end else begin
        if (r_mode_q == MODE_COUNT) r_cnt <= r_cnt + WIDTH'(1);
        if (r_mode_q == MODE_PRBS)  r_lfsr <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};

        if (r_mode_q == MODE_CHECK) begin
          r_prev     <= ui_in;
          r_prev_vld <= 1'b1;
          case (r_state)
            ST_HUNT: begin
              if (w_inc_match) begin
                r_match_cnt <= r_match_cnt + MATCH_W'(1);
                if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                  r_state <= ST_LOCKED;
                  locked  <= 1'b1;
                  r_exp   <= ui_in + WIDTH'(1);
                end
              end else begin
                r_match_cnt <= '0;
              end
            end
            ST_LOCKED: begin
              // Expected value free-runs; a bad word does not resync it
              r_exp <= r_exp + WIDTH'(1);
              if (ui_in != r_exp) begin
                err_pulse <= 1'b1;
                if (!w_err_sat) err_count <= err_count + ERR_W'(1);
              end
            end
          endcase
        end
      end
    end
  end

endmodule
